action_scheduler: RTL
=====================

Name: action_scheduler

Overview:
- Sits between the keyboard decode stage (which outputs p1move/p2move keycodes and p1bomb/p2bomb flags) and the game-state logic.
- Converts held direction keys into rate-limited, frame-aligned step strobes per player.
- Enforces per-player bomb cooldown and bomb-count limits.
- Arbitrates both players' bomb placements onto the single shared map-write port, using round-robin with a req/ack handshake.

Parameters:
- MOVE_DIV, 4: frame_ticks between consecutive steps while a direction is held (≥1).
- BOMB_COOLDOWN, 30: frame_ticks after a granted placement before the same player may request again.
- MAX_BOMBS, 2: maximum live bombs per player (≤3).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- p1move  in  8  P1 keycode: 26=up, 22=down, 4=left, 7=right, anything else=none.
- p2move  in  8  P2 keycode: 82=up, 81=down, 80=left, 79=right, anything else=none.
- p1bomb  in  1  P1 bomb key held (level).
- p2bomb  in  1  P2 bomb key held (level).
- p1_step  out  1  one-cycle step strobe, P1.
- p1_dir  out  2  P1 direction: 00 up, 01 down, 10 left, 11 right; valid with p1_step.
- p2_step  out  1  one-cycle step strobe, P2.
- p2_dir  out  2  P2 direction, same encoding; valid with p2_step.
- bomb_req  out  1  placement request to the map-write port.
- bomb_player  out  1  0=P1, 1=P2; stable while bomb_req is high.
- bomb_ack  in  1  map port accepted the request (sampled only while bomb_req=1).
- p1_bomb_done  in  1  pulse: one P1 bomb has exploded.
- p2_bomb_done  in  1  pulse: one P2 bomb has exploded.
- p1_active  out  2  live P1 bomb count.
- p2_active  out  2  live P2 bomb count.

Behaviour:
- Reset state: all outputs 0; move counters 0; cooldowns 0; active counts 0; pending flags 0; bomb-key history 0; FSM in IDLE; last_grant=1, so P1 wins the first tie.
- Move path (per player, independent):
  - Each cycle, decode the keycode into valid + dir.
  - If invalid: mcnt is cleared to 0.
  - If valid and frame_tick=1: when mcnt==0, the step strobe and dir are registered high in the next cycle (latency 1). mcnt then advances modulo MOVE_DIV. With MOVE_DIV=1, every tick steps.
  - Changing direction while valid does not reset mcnt; dir always reflects the key sampled on the stepping tick.
  - Step outputs are 0 in all other cycles.
- Bomb key path (per player):
  - A rising edge is the key high in cycle N with history low.
  - It sets pending at the end of N only if cooldown==0, active<MAX_BOMBS, and not already pending. Otherwise the press is dropped, not queued.
  - Holding the key never re-requests.
- Cooldown: loads BOMB_COOLDOWN on ack; decrements by 1 on each frame_tick, saturating at 0.
- Active count:
  - +1 on ack for that player; −1 on bomb_done, saturating at 0.
  - ack and done for the same player in the same cycle: count unchanged.
  - done at count 0: ignored.
- Arbiter FSM, states IDLE, SERVE_P1, SERVE_P2:
  - IDLE: if only one player is pending, go to that player's SERVE state. If both are pending, go to SERVE for the player ≠ last_grant. Otherwise stay in IDLE.
  - SERVE_x: bomb_req=1 and bomb_player=x (registered outputs). On a clock edge with bomb_ack=1: clear pending_x, set last_grant=x, update active/cooldown, go to IDLE. bomb_req is 0 the following cycle.
  - Without ack, the request is held indefinitely. Key activity meanwhile does not change bomb_player.
  - Latency: key edge in cycle N gives bomb_req=1 in cycle N+2.
  - IDLE lasts at least one cycle between grants.
- Reset mid-request: bomb_req and all pending state are 0 in the cycle after the reset edge. The bomb is not placed.

Test Plan:
- Hold p1move=26 with MOVE_DIV=4 and frame_tick every 10 cycles → p1_step pulses on ticks 0,4,8 (1 cycle after each), p1_dir=00. Release then repress → step on the next tick.
- p1move=99 (invalid) and p2move=81 held → p1_step never asserts; p2_step asserts with p2_dir=01.
- p1bomb and p2bomb rise in the same cycle, bomb_ack tied high → first grant bomb_player=0, then after the IDLE gap bomb_player=1. p1_active=1 and p2_active=1.
- P1 places a bomb (ack), then presses again before 30 ticks → no bomb_req. After 30 ticks, a press is granted, p1_active=2. A third press is rejected (MAX_BOMBS=2) until p1_bomb_done, after which the count reads 1 and the next press is granted.
- bomb_ack held low for 50 cycles → bomb_req and bomb_player stay stable. Assert Reset mid-request → bomb_req=0 next cycle and p1_active=0.
- p1_bomb_done coincident with P1 ack at p1_active=1 → p1_active stays 1. Done at count 0 → stays 0.

Source files
------------

// File: rtl/action_scheduler_if.sv
// Shared map-write port: one bomb placement request at a time, accepted by bomb_ack.
interface action_scheduler_if;
    logic bomb_req;
    logic bomb_player;
    logic bomb_ack;

    modport master (output bomb_req, output bomb_player, input bomb_ack);
    modport slave  (input bomb_req, input bomb_player, output bomb_ack);
endinterface

// File: rtl/action_scheduler.sv
// Turns held direction keys into frame-aligned step strobes and arbitrates
// rate-limited bomb placements from two players onto one map-write port.
module action_scheduler #(
    parameter int MOVE_DIV      = 4,
    parameter int BOMB_COOLDOWN = 30,
    parameter int MAX_BOMBS     = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_tick,
    input  logic [7:0]          p1move,
    input  logic [7:0]          p2move,
    input  logic                p1bomb,
    input  logic                p2bomb,
    output logic                p1_step,
    output logic [1:0]          p1_dir,
    output logic                p2_step,
    output logic [1:0]          p2_dir,
    action_scheduler_if.master  map,
    input  logic                p1_bomb_done,
    input  logic                p2_bomb_done,
    output logic [1:0]          p1_active,
    output logic [1:0]          p2_active
);

    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CW = (BOMB_COOLDOWN > 0) ? $clog2(BOMB_COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SERVE_P1, S_SERVE_P2} state_t;

    // Decoded key: {valid, dir[1:0]}
    function automatic logic [2:0] decode_p1(input logic [7:0] k);
        case (k)
            8'd26:   return 3'b100;
            8'd22:   return 3'b101;
            8'd4:    return 3'b110;
            8'd7:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] decode_p2(input logic [7:0] k);
        case (k)
            8'd82:   return 3'b100;
            8'd81:   return 3'b101;
            8'd80:   return 3'b110;
            8'd79:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0][MW-1:0]     mcnt_q, mcnt_d;
    logic [1:0]             step_q, step_d;
    logic [1:0][1:0]        dir_q, dir_d;
    logic [1:0]             hist_q, hist_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0][CW-1:0]     cd_q, cd_d;
    logic [1:0][1:0]        active_q, active_d;

    logic [1:0][2:0]        key;
    logic [1:0]             bomb_in;
    logic [1:0]             done_in;
    logic [1:0]             grant;

    always_comb begin
        key[0]   = decode_p1(p1move);
        key[1]   = decode_p2(p2move);
        bomb_in  = {p2bomb, p1bomb};
        done_in  = {p2_bomb_done, p1_bomb_done};
        grant[0] = (state_q == S_SERVE_P1) && map.bomb_ack;
        grant[1] = (state_q == S_SERVE_P2) && map.bomb_ack;
    end

    // Move path: mcnt keeps running across direction changes, clears on release.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mcnt_d[i] = mcnt_q[i];
            step_d[i] = 1'b0;
            dir_d[i]  = 2'b00;
            if (!key[i][2]) begin
                mcnt_d[i] = '0;
            end else if (frame_tick) begin
                if (mcnt_q[i] == '0) begin
                    step_d[i] = 1'b1;
                    dir_d[i]  = key[i][1:0];
                end
                mcnt_d[i] = (mcnt_q[i] == MW'(MOVE_DIV - 1)) ? '0 : mcnt_q[i] + 1'b1;
            end
        end
    end

    // Bomb path: presses that arrive while ineligible are dropped, never queued.
    always_comb begin
        hist_d = bomb_in;
        for (int i = 0; i < 2; i++) begin
            pend_d[i]   = pend_q[i];
            cd_d[i]     = cd_q[i];
            active_d[i] = active_q[i];
            if (grant[i]) begin
                pend_d[i] = 1'b0;
            end else if (bomb_in[i] && !hist_q[i] && (cd_q[i] == '0) &&
                         (active_q[i] < 2'(MAX_BOMBS)) && !pend_q[i]) begin
                pend_d[i] = 1'b1;
            end
            if (grant[i]) begin
                cd_d[i] = CW'(BOMB_COOLDOWN);
            end else if (frame_tick && (cd_q[i] != '0)) begin
                cd_d[i] = cd_q[i] - 1'b1;
            end
            if (grant[i] && !done_in[i]) begin
                active_d[i] = active_q[i] + 2'd1;
            end else if (!grant[i] && done_in[i] && (active_q[i] != 2'd0)) begin
                active_d[i] = active_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q == 2'b11) begin
                    state_d = last_grant_q ? S_SERVE_P1 : S_SERVE_P2;
                end else if (pend_q[0]) begin
                    state_d = S_SERVE_P1;
                end else if (pend_q[1]) begin
                    state_d = S_SERVE_P2;
                end
            end
            S_SERVE_P1: begin
                if (map.bomb_ack) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            S_SERVE_P2: begin
                if (map.bomb_ack) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        map.bomb_req    = (state_q != S_IDLE);
        map.bomb_player = (state_q == S_SERVE_P2);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant_q <= 1'b1;
            mcnt_q       <= '0;
            step_q       <= '0;
            dir_q        <= '0;
            hist_q       <= '0;
            pend_q       <= '0;
            cd_q         <= '0;
            active_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            mcnt_q       <= mcnt_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            hist_q       <= hist_d;
            pend_q       <= pend_d;
            cd_q         <= cd_d;
            active_q     <= active_d;
        end
    end

    assign p1_step   = step_q[0];
    assign p1_dir    = dir_q[0];
    assign p2_step   = step_q[1];
    assign p2_dir    = dir_q[1];
    assign p1_active = active_q[0];
    assign p2_active = active_q[1];

endmodule
